apb_mem_slave_wait: RTL and testbench

Parametrised APB4 memory slave. Successor to the fixed 8-bit-address / 32-bit-data memory slave.
- Adds configurable data/address width and depth, byte strobes, PSLVERR, and a proper access FSM.
- Wait-state generation is selectable: fixed count or LFSR-random.
- Sits behind the APB master / interconnect as a test target for protocol and bridge verification.

---
 rtl/apb_slv_pkg.sv | 29 ++
 rtl/apb_mem_slave_wait_if.sv | 28 ++
 rtl/apb_wait_lfsr.sv | 38 +++
 rtl/apb_mem_slave_wait.sv | 124 ++++++++++++
 tb/tb_apb_mem_slave_wait.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_slv_pkg.sv
// Shared types and helpers for the APB memory slave.
// Holds the FSM state enum, wait-mode codes and LFSR taps.
package apb_slv_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam int WAIT_FIXED = 0;
  localparam int WAIT_LFSR  = 1;

  // Fibonacci taps, MSB-first feedback into bit 0
  function automatic logic [7:0] lfsr_taps(input int w);
    logic [7:0] t;
    t = 8'h00;
    case (w)
      3: t = 8'b0000_0110;
      4: t = 8'b0000_1100;
      5: t = 8'b0001_0100;
      6: t = 8'b0011_0000;
      7: t = 8'b0110_0000;
      8: t = 8'b1011_1000;
      default: t = 8'h00;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/apb_mem_slave_wait_if.sv
// APB4 bus bundle between a master and the memory slave.
// Signal names keep the slave-side _i/_o suffixes.
interface apb_mem_slave_wait_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic                psel_i;
  logic                penable_i;
  logic                pwrite_i;
  logic [ADDR_W-1:0]   paddr_i;
  logic [DATA_W-1:0]   pwdata_i;
  logic [DATA_W/8-1:0] pstrb_i;
  logic [DATA_W-1:0]   prdata_o;
  logic                pready_o;
  logic                pslverr_o;

  modport master (
    output psel_i, penable_i, pwrite_i,
    output paddr_i, pwdata_i, pstrb_i,
    input  prdata_o, pready_o, pslverr_o
  );

  modport slave (
    input  psel_i, penable_i, pwrite_i,
    input  paddr_i, pwdata_i, pstrb_i,
    output prdata_o, pready_o, pslverr_o
  );
endinterface

// File: rtl/apb_wait_lfsr.sv
// Free-running maximal-length Fibonacci LFSR.
// Supplies random wait-state counts; never reaches zero.
module apb_wait_lfsr
  import apb_slv_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int SEED  = 1
) (
  input  logic             pclk_i,
  input  logic             prst_n,
  output logic [WIDTH-1:0] lfsr_o
);

  localparam logic [7:0] TAPS8 = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] TAPS = TAPS8[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_V = WIDTH'(SEED);

  if (WIDTH < 3 || WIDTH > 8) begin : g_bad_w
    $error("apb_wait_lfsr: WIDTH must be 3..8");
  end
  if (SEED_V == '0) begin : g_bad_seed
    $error("apb_wait_lfsr: SEED must be non-zero");
  end

  logic [WIDTH-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
  end

  always_ff @(posedge pclk_i or negedge prst_n) begin
    if (!prst_n) lfsr_q <= SEED_V;
    else         lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/apb_mem_slave_wait.sv
// Parametrised APB4 memory slave with fixed or LFSR wait states.
// Reports PSLVERR for out-of-range, misaligned or setup-less access.
module apb_mem_slave_wait
  import apb_slv_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 64,
  parameter int WAIT_MODE  = 1,
  parameter int FIXED_WAIT = 0,
  parameter int WAIT_W     = 3,
  parameter int LFSR_SEED  = 1
) (
  input  logic pclk_i,
  input  logic prst_n,
  apb_mem_slave_wait_if.slave bus
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BYTES - 1);

  if (!(DATA_W == 8 || DATA_W == 16 ||
        DATA_W == 32 || DATA_W == 64)) begin : g_bad_dw
    $error("apb_mem_slave_wait: illegal DATA_W");
  end
  if (DEPTH < 1 || DEPTH > (1 << (ADDR_W - OFF_W))) begin : g_bad_depth
    $error("apb_mem_slave_wait: DEPTH exceeds address space");
  end
  if (LFSR_SEED == 0) begin : g_bad_seed
    $error("apb_mem_slave_wait: LFSR_SEED must be non-zero");
  end
  if (FIXED_WAIT < 0 || FIXED_WAIT >= (1 << WAIT_W)) begin : g_bad_fw
    $error("apb_mem_slave_wait: FIXED_WAIT out of range");
  end

  state_e state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [WAIT_W-1:0] lfsr, wait_load;
  logic [ADDR_W-1:0] idx;
  logic [IDX_W-1:0]  widx;
  logic              bad, we;
  logic              pready, pslverr;
  logic [DATA_W-1:0] prdata;
  logic [DATA_W-1:0] mem_q [DEPTH];

  apb_wait_lfsr #(
    .WIDTH (WAIT_W),
    .SEED  (LFSR_SEED)
  ) u_lfsr (
    .pclk_i (pclk_i),
    .prst_n (prst_n),
    .lfsr_o (lfsr)
  );

  assign wait_load = (WAIT_MODE == WAIT_LFSR) ? lfsr
                                              : WAIT_W'(FIXED_WAIT);

  assign idx  = bus.paddr_i >> OFF_W;
  assign widx = idx[IDX_W-1:0];
  assign bad  = (32'(idx) >= 32'(DEPTH)) ||
                (|(bus.paddr_i & OFF_MASK));

  assign we = (state_q == ACCESS) && bus.psel_i &&
              (wait_q == '0) && !bad && bus.pwrite_i;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;
    if (prst_n) begin
      unique case (state_q)
        IDLE: begin
          if (bus.psel_i && !bus.penable_i) begin
            state_d = ACCESS;
            wait_d  = wait_load;
          end else if (bus.psel_i && bus.penable_i) begin
            // access phase without setup: reject in-cycle
            pready  = 1'b1;
            pslverr = 1'b1;
          end
        end
        ACCESS: begin
          if (!bus.psel_i) begin
            state_d = IDLE;
          end else if (wait_q != '0) begin
            wait_d = wait_q - 1'b1;
          end else begin
            pready  = 1'b1;
            pslverr = bad;
            state_d = IDLE;
            if (!bad && !bus.pwrite_i) prdata = mem_q[widx];
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk_i or negedge prst_n) begin
    if (!prst_n) begin
      state_q <= IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_ff @(posedge pclk_i) begin
    for (int b = 0; b < BYTES; b++) begin
      if (we && bus.pstrb_i[b])
        mem_q[widx][8*b +: 8] <= bus.pwdata_i[8*b +: 8];
    end
  end

  assign bus.pready_o  = pready;
  assign bus.pslverr_o = pslverr;
  assign bus.prdata_o  = prdata;

endmodule

// File: tb/tb_apb_mem_slave_wait.sv
// Directed scoreboard bench: three slave instances covering
// zero wait, LFSR wait and fixed three-cycle wait.
module tb_apb_mem_slave_wait;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  psel;
  logic        penable, pwrite;
  logic [9:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;

  int n_chk = 0;
  int n_fail = 0;
  int cur = 0;
  int edge_cnt;
  int lseq [7] = '{1, 2, 5, 3, 7, 6, 4};

  typedef struct {
    string       tag;
    logic        err;
    logic [31:0] rdata;
    int          wait_n;
  } exp_t;
  exp_t exp_q [$];

  logic        pr, pe;
  logic [31:0] rd;

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;

  apb_mem_slave_wait_if #(.ADDR_W(10), .DATA_W(32)) if0 ();
  apb_mem_slave_wait_if #(.ADDR_W(10), .DATA_W(32)) if1 ();
  apb_mem_slave_wait_if #(.ADDR_W(10), .DATA_W(32)) if2 ();

  assign if0.psel_i = psel[0];
  assign if1.psel_i = psel[1];
  assign if2.psel_i = psel[2];
  assign if0.penable_i = penable;
  assign if1.penable_i = penable;
  assign if2.penable_i = penable;
  assign if0.pwrite_i = pwrite;
  assign if1.pwrite_i = pwrite;
  assign if2.pwrite_i = pwrite;
  assign if0.paddr_i = paddr;
  assign if1.paddr_i = paddr;
  assign if2.paddr_i = paddr;
  assign if0.pwdata_i = pwdata;
  assign if1.pwdata_i = pwdata;
  assign if2.pwdata_i = pwdata;
  assign if0.pstrb_i = pstrb;
  assign if1.pstrb_i = pstrb;
  assign if2.pstrb_i = pstrb;

  apb_mem_slave_wait #(
    .ADDR_W(10), .DATA_W(32), .DEPTH(64),
    .WAIT_MODE(0), .FIXED_WAIT(0), .WAIT_W(3), .LFSR_SEED(1)
  ) dut0 (.pclk_i(clk), .prst_n(rst_n), .bus(if0));

  apb_mem_slave_wait #(
    .ADDR_W(10), .DATA_W(32), .DEPTH(64),
    .WAIT_MODE(1), .FIXED_WAIT(0), .WAIT_W(3), .LFSR_SEED(1)
  ) dut1 (.pclk_i(clk), .prst_n(rst_n), .bus(if1));

  apb_mem_slave_wait #(
    .ADDR_W(10), .DATA_W(32), .DEPTH(64),
    .WAIT_MODE(0), .FIXED_WAIT(3), .WAIT_W(3), .LFSR_SEED(1)
  ) dut2 (.pclk_i(clk), .prst_n(rst_n), .bus(if2));

  always_comb begin
    pr = if0.pready_o;
    pe = if0.pslverr_o;
    rd = if0.prdata_o;
    if (cur == 1) begin
      pr = if1.pready_o;
      pe = if1.pslverr_o;
      rd = if1.prdata_o;
    end else if (cur == 2) begin
      pr = if2.pready_o;
      pe = if2.pslverr_o;
      rd = if2.prdata_o;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // one full transfer; ewait < 0 takes the wait from the LFSR model
  task automatic xfer(input int d, input string tag, input logic wr,
                      input logic [9:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input logic eerr,
                      input logic [31:0] erd, input int ewait);
    exp_t e;
    int   n;
    logic got;
    e.tag    = tag;
    e.err    = eerr;
    e.rdata  = erd;
    e.wait_n = (ewait < 0) ? lseq[edge_cnt % 7] : ewait;
    exp_q.push_back(e);
    cur     = d;
    psel    = 3'b000;
    psel[d] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = wd;
    pstrb   = st;
    @(posedge clk);
    #1 penable = 1'b1;
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      if (pr === 1'b1) got = 1'b1;
      else n++;
    end
    e = exp_q.pop_front();
    chk({e.tag, " ready"}, 32'(got), 32'd1);
    chk({e.tag, " wait"}, n, e.wait_n);
    chk({e.tag, " err"}, 32'(pe), 32'(e.err));
    chk({e.tag, " rdata"}, rd, e.rdata);
    @(posedge clk);
    #1;
    psel    = 3'b000;
    penable = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    psel = 3'b000;
    penable = 1'b0;
    pwrite = 1'b0;
    paddr = '0;
    pwdata = '0;
    pstrb = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      cur = i;
      #1;
      chk("rst pready", 32'(pr), 32'd0);
      chk("rst pslverr", 32'(pe), 32'd0);
      chk("rst prdata", rd, 32'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;

    xfer(0, "wr10", 1, 10'h010, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    xfer(0, "rd10", 0, 10'h010, 0, 4'hF, 0, 32'hDEADBEEF, 0);
    xfer(0, "wr04a", 1, 10'h004, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    xfer(0, "wr04b", 1, 10'h004, 32'h00AA00BB, 4'h5, 0, 0, 0);
    xfer(0, "rd04", 0, 10'h004, 0, 4'h0, 0, 32'hFFAAFFBB, 0);
    xfer(0, "wr00", 1, 10'h000, 32'h12345678, 4'hF, 0, 0, 0);
    xfer(0, "rd100", 0, 10'h100, 0, 4'hF, 1, 0, 0);
    xfer(0, "wr02", 1, 10'h002, 32'hCAFEF00D, 4'hF, 1, 0, 0);
    xfer(0, "rd00", 0, 10'h000, 0, 4'hF, 0, 32'h12345678, 0);
    xfer(0, "wr10s0", 1, 10'h010, 32'h0, 4'h0, 0, 0, 0);
    xfer(0, "rd10s0", 0, 10'h010, 0, 4'h0, 0, 32'hDEADBEEF, 0);

    cur = 0;
    psel = 3'b001;
    penable = 1'b1;
    pwrite = 1'b1;
    paddr = 10'h010;
    pwdata = 32'h55555555;
    pstrb = 4'hF;
    @(negedge clk);
    chk("nosetup pready", 32'(pr), 32'd1);
    chk("nosetup pslverr", 32'(pe), 32'd1);
    chk("nosetup prdata", rd, 32'd0);
    @(posedge clk);
    #1;
    psel = 3'b000;
    penable = 1'b0;
    xfer(0, "rd10np", 0, 10'h010, 0, 4'h0, 0, 32'hDEADBEEF, 0);

    xfer(1, "lwr08", 1, 10'h008, 32'hA5A55A5A, 4'hF, 0, 0, -1);
    for (int i = 0; i < 8; i++) begin
      xfer(1, "lrd08", 0, 10'h008, 0, 4'h0, 0, 32'hA5A55A5A, -1);
      if (i % 3 == 1) idle(i);
    end

    xfer(2, "fwr20", 1, 10'h020, 32'h11112222, 4'hF, 0, 0, 3);
    cur = 2;
    psel = 3'b100;
    penable = 1'b0;
    pwrite = 1'b1;
    paddr = 10'h020;
    pwdata = 32'h99999999;
    pstrb = 4'hF;
    @(posedge clk);
    #1 penable = 1'b1;
    @(negedge clk);
    chk("abort wait pready", 32'(pr), 32'd0);
    @(posedge clk);
    #1;
    psel = 3'b000;
    penable = 1'b0;
    @(negedge clk);
    chk("abort drop pready", 32'(pr), 32'd0);
    @(posedge clk);
    #1;
    xfer(2, "abort rd20", 0, 10'h020, 0, 4'h0, 0, 32'h11112222, 3);

    cur = 2;
    psel = 3'b100;
    penable = 1'b0;
    pwrite = 1'b1;
    paddr = 10'h020;
    pwdata = 32'h77777777;
    pstrb = 4'hF;
    @(posedge clk);
    #1 penable = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst pready", 32'(pr), 32'd0);
    chk("midrst pslverr", 32'(pe), 32'd0);
    chk("midrst prdata", rd, 32'd0);
    psel = 3'b000;
    penable = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    xfer(2, "rst rd20", 0, 10'h020, 0, 4'h0, 0, 32'h11112222, 3);
    xfer(1, "rst lrd08", 0, 10'h008, 0, 4'h0, 0, 32'hA5A55A5A, -1);
    xfer(1, "rst lrd08b", 0, 10'h008, 0, 4'h0, 0, 32'hA5A55A5A, -1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
